// File: rtl/vga_pkg.sv
// Shared pong game types and match timing defaults for sequencer, renderer and score display.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        SERVE = 3'd1,
        RALLY = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } match_state_t;

    localparam int WIN_SCORE_DEF   = 5;
    localparam int SERVE_TICKS_DEF = 60;
    localparam int POINT_TICKS_DEF = 90;
    localparam int CNT_W_DEF       = 8;

    // Score increment that sticks at the match-winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter stepped by an enable strobe; expire fires on a strobe while count <= 1.
// Latency: count updates one cycle after load/en; expire is combinational from en and count.
// Backpressure: none; a strobe at zero holds zero and still expires.
module tick_countdown
    import vga_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    assign expire = en && (count <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Pong match controller: serve/rally/point/pause sequencing, scoring and winner decision.
// Latency: button edges and misses act on the next clock; gating outputs decode the state register.
// Backpressure: none; events outside the states that accept them are dropped.
module match_sequencer
    import vga_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int SERVE_TICKS = SERVE_TICKS_DEF,
    parameter int POINT_TICKS = POINT_TICKS_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timing_tick,
    input  logic             start_btn,
    input  logic             pause_btn,
    input  logic             restart_btn,
    input  logic             miss_left,
    input  logic             miss_right,
    output logic [2:0]       state,
    output logic             ball_enable,
    output logic             ball_reset,
    output logic             pad_enable,
    output logic             serve_dir,
    output logic [3:0]       player1_score,
    output logic [3:0]       player2_score,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] countdown
);

    localparam logic [CNT_W-1:0] SERVE_VAL = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0] POINT_VAL = CNT_W'(POINT_TICKS);
    localparam logic [3:0]       WIN_VAL   = 4'(WIN_SCORE);

    match_state_t state_r, state_n;
    logic [3:0]   p1_r, p1_n, p2_r, p2_n;
    logic [1:0]   win_r, win_n;
    logic         dir_r, dir_n;
    logic         start_q, pause_q, restart_q;
    logic         start_edge, pause_edge, restart_edge;
    logic         cnt_clr, cnt_load, cnt_en, cnt_expire;
    logic [CNT_W-1:0] cnt_val;

    assign start_edge   = start_btn   & ~start_q;
    assign pause_edge   = pause_btn   & ~pause_q;
    assign restart_edge = restart_btn & ~restart_q;

    tick_countdown #(.CNT_W(CNT_W)) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (countdown),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= MENU;
            p1_r      <= 4'd0;
            p2_r      <= 4'd0;
            win_r     <= 2'd0;
            dir_r     <= 1'b1;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_r   <= state_n;
            p1_r      <= p1_n;
            p2_r      <= p2_n;
            win_r     <= win_n;
            dir_r     <= dir_n;
            start_q   <= start_btn;
            pause_q   <= pause_btn;
            restart_q <= restart_btn;
        end
    end

    always_comb begin
        state_n  = state_r;
        p1_n     = p1_r;
        p2_n     = p2_r;
        win_n    = win_r;
        dir_n    = dir_r;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = SERVE_VAL;
        cnt_en   = 1'b0;

        if (restart_edge) begin
            state_n = MENU;
            p1_n    = 4'd0;
            p2_n    = 4'd0;
            win_n   = 2'd0;
            cnt_clr = 1'b1;
        end else begin
            case (state_r)
                MENU, OVER: begin
                    if (start_edge) begin
                        state_n  = SERVE;
                        p1_n     = 4'd0;
                        p2_n     = 4'd0;
                        win_n    = 2'd0;
                        dir_n    = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = SERVE_VAL;
                    end
                end
                SERVE: begin
                    cnt_en = timing_tick;
                    if (cnt_expire) begin
                        state_n = RALLY;
                    end
                end
                RALLY: begin
                    // miss_left wins a coincident pair; the serve then goes toward the conceding side
                    if (miss_left) begin
                        p2_n     = sat_inc(p2_r, WIN_VAL);
                        dir_n    = 1'b0;
                        state_n  = POINT;
                        cnt_load = 1'b1;
                        cnt_val  = POINT_VAL;
                    end else if (miss_right) begin
                        p1_n     = sat_inc(p1_r, WIN_VAL);
                        dir_n    = 1'b1;
                        state_n  = POINT;
                        cnt_load = 1'b1;
                        cnt_val  = POINT_VAL;
                    end else if (pause_edge) begin
                        state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause_edge) begin
                        state_n = RALLY;
                    end
                end
                POINT: begin
                    cnt_en = timing_tick;
                    if (cnt_expire) begin
                        if (p1_r == WIN_VAL) begin
                            state_n = OVER;
                            win_n   = 2'd1;
                        end else if (p2_r == WIN_VAL) begin
                            state_n = OVER;
                            win_n   = 2'd2;
                        end else begin
                            state_n  = SERVE;
                            cnt_load = 1'b1;
                            cnt_val  = SERVE_VAL;
                        end
                    end
                end
                default: begin
                    state_n = MENU;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign state         = state_r;
    assign ball_enable   = (state_r == RALLY);
    assign ball_reset    = (state_r == MENU) || (state_r == SERVE) || (state_r == OVER);
    assign pad_enable    = (state_r == SERVE) || (state_r == RALLY);
    assign serve_dir     = dir_r;
    assign player1_score = p1_r;
    assign player2_score = p2_r;
    assign winner        = win_r;

endmodule

// File: tb/tb_match_sequencer.sv
// Scenario tests plus randomized run against a rule-level match model.
module tb_match_sequencer;

    localparam int WIN = 5, ST = 60, PT = 90;
    localparam int S_MENU = 0, S_SERVE = 1, S_RALLY = 2, S_PAUSE = 3, S_POINT = 4, S_OVER = 5;

    logic clk = 1'b0;
    logic rst = 1'b0, timing_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
    logic restart_btn = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
    logic [2:0] state;
    logic       ball_enable, ball_reset, pad_enable, serve_dir;
    logic [3:0] player1_score, player2_score;
    logic [1:0] winner;
    logic [7:0] countdown;

    int vectors = 0, miscompares = 0;
    int m_state = S_MENU, m_p1 = 0, m_p2 = 0, m_win = 0, m_dir = 1, m_cnt = 0;
    bit m_sq = 0, m_pq = 0, m_rq = 0;

    always #5 clk = ~clk;

    match_sequencer #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_TICKS(PT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .timing_tick(timing_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .restart_btn(restart_btn), .miss_left(miss_left),
        .miss_right(miss_right), .state(state), .ball_enable(ball_enable),
        .ball_reset(ball_reset), .pad_enable(pad_enable), .serve_dir(serve_dir),
        .player1_score(player1_score), .player2_score(player2_score),
        .winner(winner), .countdown(countdown)
    );

    // Match rules applied to the inputs seen at one rising edge.
    task automatic model_update();
        bit se, pe, re;
        se = start_btn && !m_sq;
        pe = pause_btn && !m_pq;
        re = restart_btn && !m_rq;
        m_sq = start_btn; m_pq = pause_btn; m_rq = restart_btn;
        if (!rst) begin
            m_state = S_MENU; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_cnt = 0;
            m_sq = 0; m_pq = 0; m_rq = 0;
        end else if (re) begin
            m_state = S_MENU; m_p1 = 0; m_p2 = 0; m_win = 0; m_cnt = 0;
        end else begin
            case (m_state)
                S_MENU, S_OVER: if (se) begin
                    m_state = S_SERVE; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_cnt = ST;
                end
                S_SERVE: if (timing_tick) begin
                    if (m_cnt <= 1) begin m_state = S_RALLY; m_cnt = 0; end
                    else m_cnt = m_cnt - 1;
                end
                S_RALLY: begin
                    if (miss_left) begin
                        if (m_p2 < WIN) m_p2 = m_p2 + 1;
                        m_dir = 0; m_state = S_POINT; m_cnt = PT;
                    end else if (miss_right) begin
                        if (m_p1 < WIN) m_p1 = m_p1 + 1;
                        m_dir = 1; m_state = S_POINT; m_cnt = PT;
                    end else if (pe) m_state = S_PAUSE;
                end
                S_PAUSE: if (pe) m_state = S_RALLY;
                S_POINT: if (timing_tick) begin
                    if (m_cnt <= 1) begin
                        m_cnt = 0;
                        if (m_p1 == WIN) begin m_state = S_OVER; m_win = 1; end
                        else if (m_p2 == WIN) begin m_state = S_OVER; m_win = 2; end
                        else begin m_state = S_SERVE; m_cnt = ST; end
                    end else m_cnt = m_cnt - 1;
                end
                default: m_state = S_MENU;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic advance_out(input int src, input int budget);
        int n = 0;
        while (m_state == src && n < budget) begin
            timing_tick = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        timing_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        vectors++; if (state !== 3'(S_MENU)) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state, S_MENU); end
        vectors++; if ({player1_score, player2_score, winner} !== 10'd0) begin miscompares++; $display("FAIL reset_scores: got %0d:%0d w%0d want 0:0 w0", player1_score, player2_score, winner); end
        vectors++; if ({serve_dir, countdown} !== {1'b1, 8'd0}) begin miscompares++; $display("FAIL reset_dir_cnt: got dir %0d cnt %0d want 1 0", serve_dir, countdown); end
        vectors++; if ({ball_enable, ball_reset, pad_enable} !== 3'b010) begin miscompares++; $display("FAIL reset_flags: got %b want 010", {ball_enable, ball_reset, pad_enable}); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_serve();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        vectors++; if ({state, countdown, ball_reset} !== {3'(S_SERVE), 8'd60, 1'b1}) begin miscompares++; $display("FAIL serve_entry: got st %0d cnt %0d br %0d want 1 60 1", state, countdown, ball_reset); end
        // exactly 59 ticks must not release the ball
        for (int i = 0; i < 59; i++) begin timing_tick = 1'b1; step(); end
        timing_tick = 1'b0;
        vectors++; if ({state, countdown} !== {3'(S_SERVE), 8'd1}) begin miscompares++; $display("FAIL serve_59: got st %0d cnt %0d want 1 1", state, countdown); end
        timing_tick = 1'b1; step(); timing_tick = 1'b0;
        vectors++; if ({state, ball_enable, countdown} !== {3'(S_RALLY), 1'b1, 8'd0}) begin miscompares++; $display("FAIL serve_release: got st %0d be %0d cnt %0d want 2 1 0", state, ball_enable, countdown); end
    endtask

    task automatic test_miss();
        miss_left = 1'b1; step(); miss_left = 1'b0;
        vectors++; if ({player2_score, serve_dir, state, countdown} !== {4'd1, 1'b0, 3'(S_POINT), 8'd90}) begin miscompares++; $display("FAIL miss_left: got p2 %0d dir %0d st %0d cnt %0d want 1 0 4 90", player2_score, serve_dir, state, countdown); end
        vectors++; if ({ball_enable, ball_reset} !== 2'b00) begin miscompares++; $display("FAIL point_frozen: got %b want 00", {ball_enable, ball_reset}); end
        advance_out(S_POINT, 2000);
        vectors++; if ({state, countdown} !== {3'(S_SERVE), 8'd60}) begin miscompares++; $display("FAIL point_expire: got st %0d cnt %0d want 1 60", state, countdown); end
    endtask

    task automatic test_win();
        for (int i = 0; i < 5; i++) begin
            advance_out(S_SERVE, 2000);
            miss_right = 1'b1; step(); miss_right = 1'b0;
            vectors++; if (player1_score !== 4'(i + 1)) begin miscompares++; $display("FAIL win_p1_step: got %0d want %0d", player1_score, i + 1); end
            advance_out(S_POINT, 2000);
        end
        vectors++; if ({state, winner, player1_score} !== {3'(S_OVER), 2'd1, 4'd5}) begin miscompares++; $display("FAIL win_over: got st %0d w %0d p1 %0d want 5 1 5", state, winner, player1_score); end
        miss_right = 1'b1; step(); miss_right = 1'b0;
        vectors++; if ({state, player1_score} !== {3'(S_OVER), 4'd5}) begin miscompares++; $display("FAIL over_miss_ignored: got st %0d p1 %0d want 5 5", state, player1_score); end
    endtask

    task automatic test_pause();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        vectors++; if ({state, player1_score, winner, serve_dir} !== {3'(S_SERVE), 4'd0, 2'd0, 1'b1}) begin miscompares++; $display("FAIL over_restart: got st %0d p1 %0d w %0d dir %0d want 1 0 0 1", state, player1_score, winner, serve_dir); end
        advance_out(S_SERVE, 2000);
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        vectors++; if ({state, ball_enable, pad_enable} !== {3'(S_PAUSE), 2'b00}) begin miscompares++; $display("FAIL pause_enter: got st %0d be %0d pe %0d want 3 0 0", state, ball_enable, pad_enable); end
        timing_tick = 1'b1; miss_right = 1'b1;
        repeat (5) step();
        timing_tick = 1'b0; miss_right = 1'b0;
        vectors++; if ({state, player1_score, player2_score} !== {3'(S_PAUSE), 8'd0}) begin miscompares++; $display("FAIL pause_frozen: got st %0d %0d:%0d want 3 0:0", state, player1_score, player2_score); end
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        vectors++; if (state !== 3'(S_RALLY)) begin miscompares++; $display("FAIL pause_exit: got %0d want 2", state); end
    endtask

    task automatic test_simultaneous();
        miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
        vectors++; if ({player1_score, player2_score, serve_dir} !== {4'd0, 4'd1, 1'b0}) begin miscompares++; $display("FAIL simul_miss: got %0d:%0d dir %0d want 0:1 dir 0", player1_score, player2_score, serve_dir); end
    endtask

    task automatic test_restart();
        bit pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            advance_out(S_POINT, 2000);
            advance_out(S_SERVE, 2000);
            if (pat[i]) miss_right = 1'b1; else miss_left = 1'b1;
            step();
            miss_right = 1'b0; miss_left = 1'b0;
        end
        vectors++; if ({state, player1_score, player2_score} !== {3'(S_POINT), 4'd3, 4'd2}) begin miscompares++; $display("FAIL restart_setup: got st %0d %0d:%0d want 4 3:2", state, player1_score, player2_score); end
        restart_btn = 1'b1; timing_tick = 1'b1; step(); timing_tick = 1'b0;
        vectors++; if ({state, player1_score, player2_score, countdown} !== {3'(S_MENU), 16'd0}) begin miscompares++; $display("FAIL restart: got st %0d %0d:%0d cnt %0d want 0 0:0 0", state, player1_score, player2_score, countdown); end
        step(); restart_btn = 1'b0; step();
    endtask

    task automatic test_held_start();
        int entries = 0;
        logic [2:0] prev;
        prev = state;
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state == 3'(S_SERVE) && prev != 3'(S_SERVE)) entries++;
            prev = state;
        end
        start_btn = 1'b0;
        vectors++; if (entries !== 1) begin miscompares++; $display("FAIL held_start: got %0d serve entries want 1", entries); end
        vectors++; if ({state, countdown} !== {3'(S_SERVE), 8'd60}) begin miscompares++; $display("FAIL held_start_state: got st %0d cnt %0d want 1 60", state, countdown); end
    endtask

    task automatic test_rst_mid();
        advance_out(S_SERVE, 2000);
        miss_right = 1'b1; step(); miss_right = 1'b0;
        advance_out(S_POINT, 2000);
        advance_out(S_SERVE, 2000);
        rst = 1'b0; step();
        vectors++; if ({state, player1_score, player2_score, winner, serve_dir, countdown, ball_enable, ball_reset, pad_enable} !== {3'(S_MENU), 10'd0, 1'b1, 8'd0, 3'b010}) begin miscompares++; $display("FAIL rst_mid: got st %0d %0d:%0d w %0d dir %0d cnt %0d want menu defaults", state, player1_score, player2_score, winner, serve_dir, countdown); end
        rst = 1'b1; step();
    endtask

    task automatic test_random();
        logic [25:0] got, exp;
        for (int i = 0; i < 6000; i++) begin
            timing_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 29) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 199) == 0) restart_btn = ~restart_btn;
            miss_left  = ($urandom_range(0, 14) == 0);
            miss_right = ($urandom_range(0, 14) == 0);
            rst = ($urandom_range(0, 1499) != 0);
            step();
            exp = {3'(m_state), m_state == S_RALLY,
                   m_state == S_MENU || m_state == S_SERVE || m_state == S_OVER,
                   m_state == S_SERVE || m_state == S_RALLY,
                   1'(m_dir), 4'(m_p1), 4'(m_p2), 2'(m_win), 8'(m_cnt)};
            got = {state, ball_enable, ball_reset, pad_enable, serve_dir,
                   player1_score, player2_score, winner, countdown};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random_cycle %0d: got %h want %h", i, got, exp);
            end
        end
        {timing_tick, start_btn, pause_btn, restart_btn, miss_left, miss_right} = 6'd0;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_miss();
        test_win();
        test_pause();
        test_simultaneous();
        test_restart();
        test_held_start();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
